// File: rtl/ifu_fetch_ctrl.sv
// Fetch controller: owns the PC, keeps one IF request in flight and registers a {pc, instr, flags} packet for decode.
// Request-to-packet-valid latency is 2 cycles (3 cycles per instruction); a stalled decode holds the packet and blocks new fetches.
module ifu_fetch_ctrl #(
   parameter int                  PC_WIDTH    = 32,
   parameter int                  INSTR_WIDTH = 32,
   parameter logic [PC_WIDTH-1:0] RESET_PC    = '0
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic                   flush_valid_i,
   input  logic [PC_WIDTH-1:0]    flush_pc_i,
   output logic                   if_req_valid_o,
   input  logic                   if_req_ready_i,
   output logic [PC_WIDTH-1:0]    if_req_pc_o,
   input  logic                   if_resp_valid_i,
   output logic                   if_resp_ready_o,
   input  logic                   if_resp_bus_err_i,
   input  logic [INSTR_WIDTH-1:0] if_resp_instr_i,
   output logic                   ifu_o_valid,
   input  logic                   ifu_o_ready,
   output logic [PC_WIDTH-1:0]    ifu_o_pc,
   output logic [INSTR_WIDTH-1:0] ifu_o_instr,
   output logic                   ifu_o_misalign,
   output logic                   ifu_o_bus_err
);

   typedef enum logic [1:0] {
      S_REQ  = 2'd0,
      S_WAIT = 2'd1,
      S_OUT  = 2'd2
   } state_t;

   typedef struct packed {
      logic [PC_WIDTH-1:0]    pc;
      logic [INSTR_WIDTH-1:0] instr;
      logic                   misalign;
      logic                   bus_err;
   } pkt_t;

   state_t              state_r;
   state_t              state_nxt;
   logic [PC_WIDTH-1:0] pc_r;
   logic [PC_WIDTH-1:0] pc_nxt;
   logic                drop_r;
   logic                drop_nxt;
   pkt_t                pkt_r;
   pkt_t                pkt_nxt;
   logic                pc_aligned;
   logic                req_hs;

   assign pc_aligned = (pc_r[1:0] == 2'b00);

   // Flush gates the request combinationally so a stale address is never accepted.
   assign if_req_valid_o  = !rst_i && !flush_valid_i && (state_r == S_REQ) && pc_aligned;
   assign if_req_pc_o     = pc_r;
   assign if_resp_ready_o = !rst_i && (state_r == S_WAIT);
   assign req_hs          = if_req_valid_o && if_req_ready_i;

   assign ifu_o_valid    = (state_r == S_OUT);
   assign ifu_o_pc       = pkt_r.pc;
   assign ifu_o_instr    = pkt_r.instr;
   assign ifu_o_misalign = pkt_r.misalign;
   assign ifu_o_bus_err  = pkt_r.bus_err;

   always_comb begin
      state_nxt = state_r;
      pc_nxt    = pc_r;
      drop_nxt  = drop_r;
      pkt_nxt   = pkt_r;

      if (flush_valid_i) begin
         pc_nxt = flush_pc_i;
         unique case (state_r)
            S_REQ: begin
               state_nxt = S_REQ;
            end
            S_WAIT: begin
               // A response landing in the flush cycle belongs to the old path.
               if (if_resp_valid_i) begin
                  drop_nxt  = 1'b0;
                  state_nxt = S_REQ;
               end else begin
                  drop_nxt  = 1'b1;
               end
            end
            S_OUT: begin
               state_nxt = S_REQ;
            end
            default: begin
               state_nxt = S_REQ;
            end
         endcase
      end else begin
         unique case (state_r)
            S_REQ: begin
               if (!pc_aligned) begin
                  pkt_nxt.pc       = pc_r;
                  pkt_nxt.instr    = '0;
                  pkt_nxt.misalign = 1'b1;
                  pkt_nxt.bus_err  = 1'b0;
                  state_nxt        = S_OUT;
               end else if (req_hs) begin
                  state_nxt = S_WAIT;
               end
            end
            S_WAIT: begin
               if (if_resp_valid_i) begin
                  if (drop_r) begin
                     drop_nxt  = 1'b0;
                     state_nxt = S_REQ;
                  end else begin
                     pkt_nxt.pc       = pc_r;
                     pkt_nxt.instr    = if_resp_bus_err_i ? '0 : if_resp_instr_i;
                     pkt_nxt.misalign = 1'b0;
                     pkt_nxt.bus_err  = if_resp_bus_err_i;
                     state_nxt        = S_OUT;
                  end
               end
            end
            S_OUT: begin
               if (ifu_o_ready) begin
                  pc_nxt    = pc_r + PC_WIDTH'(4);
                  state_nxt = S_REQ;
               end
            end
            default: begin
               state_nxt = S_REQ;
            end
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_r <= S_REQ;
         pc_r    <= RESET_PC;
         drop_r  <= 1'b0;
         pkt_r   <= '0;
      end else begin
         state_r <= state_nxt;
         pc_r    <= pc_nxt;
         drop_r  <= drop_nxt;
         pkt_r   <= pkt_nxt;
      end
   end

endmodule

// File: tb/tb_ifu_fetch_ctrl.sv
// Bench for ifu_fetch_ctrl: a memory responder model plus request/packet scoreboards fed by directed stimulus.
module tb_ifu_fetch_ctrl;

   logic        clk_i;
   logic        rst_i;
   logic        flush_valid_i;
   logic [31:0] flush_pc_i;
   logic        if_req_valid_o;
   logic        if_req_ready_i;
   logic [31:0] if_req_pc_o;
   logic        if_resp_valid_i;
   logic        if_resp_ready_o;
   logic        if_resp_bus_err_i;
   logic [31:0] if_resp_instr_i;
   logic        ifu_o_valid;
   logic        ifu_o_ready;
   logic [31:0] ifu_o_pc;
   logic [31:0] ifu_o_instr;
   logic        ifu_o_misalign;
   logic        ifu_o_bus_err;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
      logic        mis;
      logic        berr;
   } exp_t;

   exp_t        pkt_q[$];
   logic [31:0] req_q[$];
   int          n_chk = 0;
   int          n_pass = 0;
   int          resp_delay = 0;
   logic [31:0] berr_addr = 32'h0000_0001;

   ifu_fetch_ctrl #(
      .PC_WIDTH    (32),
      .INSTR_WIDTH (32),
      .RESET_PC    (32'h0000_0000)
   ) dut (
      .clk_i             (clk_i),
      .rst_i             (rst_i),
      .flush_valid_i     (flush_valid_i),
      .flush_pc_i        (flush_pc_i),
      .if_req_valid_o    (if_req_valid_o),
      .if_req_ready_i    (if_req_ready_i),
      .if_req_pc_o       (if_req_pc_o),
      .if_resp_valid_i   (if_resp_valid_i),
      .if_resp_ready_o   (if_resp_ready_o),
      .if_resp_bus_err_i (if_resp_bus_err_i),
      .if_resp_instr_i   (if_resp_instr_i),
      .ifu_o_valid       (ifu_o_valid),
      .ifu_o_ready       (ifu_o_ready),
      .ifu_o_pc          (ifu_o_pc),
      .ifu_o_instr       (ifu_o_instr),
      .ifu_o_misalign    (ifu_o_misalign),
      .ifu_o_bus_err     (ifu_o_bus_err)
   );

   initial begin
      clk_i = 1'b0;
      forever #5 clk_i = ~clk_i;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish, required finish before 200000");
      $fatal(1, "timeout");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: actual %h required %h", name, act, exp);
   endtask

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      if (a == 32'h0) return 32'h0000_0013;
      if (a == 32'h4) return 32'h0010_0093;
      return 32'hC0DE_0000 ^ a;
   endfunction

   function automatic exp_t mk(input logic [31:0] pc, input logic [31:0] instr,
                               input logic mis, input logic berr);
      exp_t e;
      e.pc = pc; e.instr = instr; e.mis = mis; e.berr = berr;
      return e;
   endfunction

   // Memory side: answers each accepted request after resp_delay idle cycles.
   initial begin
      logic        rq;
      logic        rs;
      logic        rr;
      logic        pend;
      logic [31:0] lat_pc;
      int          cnt;
      if_resp_valid_i = 1'b0;
      if_resp_instr_i = '0;
      if_resp_bus_err_i = 1'b0;
      pend = 1'b0;
      lat_pc = '0;
      cnt = 0;
      forever begin
         @(negedge clk_i);
         rq = if_req_valid_o && if_req_ready_i;
         rs = if_resp_valid_i && if_resp_ready_o;
         rr = rst_i;
         if (rq) lat_pc = if_req_pc_o;
         @(posedge clk_i);
         #1;
         if (rr) begin
            pend = 1'b0;
            if_resp_valid_i = 1'b0;
         end else begin
            if (rs) begin
               pend = 1'b0;
               if_resp_valid_i = 1'b0;
            end
            if (rq) begin
               pend = 1'b1;
               cnt = resp_delay;
            end
            if (pend && !if_resp_valid_i) begin
               if (cnt == 0) begin
                  if_resp_valid_i = 1'b1;
                  if_resp_instr_i = mem_word(lat_pc);
                  if_resp_bus_err_i = (lat_pc == berr_addr);
               end else begin
                  cnt--;
               end
            end
         end
      end
   end

   // Request monitor.
   initial begin
      logic [31:0] e;
      forever begin
         @(negedge clk_i);
         if (if_req_valid_o && if_req_ready_i) begin
            if (req_q.size() == 0) begin
               n_chk++;
               $display("FAIL req_unexpected: actual request pc %h, required no request", if_req_pc_o);
            end else begin
               e = req_q.pop_front();
               chk("req_pc", if_req_pc_o, e);
            end
         end
      end
   end

   // Packet monitor.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk_i);
         if (ifu_o_valid && ifu_o_ready) begin
            if (pkt_q.size() == 0) begin
               n_chk++;
               $display("FAIL pkt_unexpected: actual packet pc %h, required no packet", ifu_o_pc);
            end else begin
               e = pkt_q.pop_front();
               chk("pkt_pc", ifu_o_pc, e.pc);
               chk("pkt_instr", ifu_o_instr, e.instr);
               chk("pkt_misalign", 32'(ifu_o_misalign), 32'(e.mis));
               chk("pkt_bus_err", 32'(ifu_o_bus_err), 32'(e.berr));
            end
         end
      end
   end

   task automatic cyc();
      @(posedge clk_i);
      #1;
   endtask

   task automatic wait_req(input logic [31:0] pc, input string name);
      int t = 0;
      @(negedge clk_i);
      while (!(if_req_valid_o && if_req_pc_o == pc) && t < 40) begin
         @(negedge clk_i);
         t++;
      end
      chk(name, 32'(t < 40), 32'd1);
   endtask

   task automatic wait_pkt(input logic [31:0] pc, input string name);
      int t = 0;
      @(negedge clk_i);
      while (!(ifu_o_valid && ifu_o_pc == pc) && t < 40) begin
         @(negedge clk_i);
         t++;
      end
      chk(name, 32'(t < 40), 32'd1);
   endtask

   initial begin
      int t;
      rst_i = 1'b1;
      flush_valid_i = 1'b0;
      flush_pc_i = '0;
      if_req_ready_i = 1'b1;
      ifu_o_ready = 1'b1;

      repeat (3) @(posedge clk_i);
      @(negedge clk_i);
      chk("rst_valid", 32'(ifu_o_valid), 32'd0);
      chk("rst_pc", ifu_o_pc, 32'h0);
      chk("rst_instr", ifu_o_instr, 32'h0);
      chk("rst_misalign", 32'(ifu_o_misalign), 32'd0);
      chk("rst_bus_err", 32'(ifu_o_bus_err), 32'd0);
      chk("rst_req_valid", 32'(if_req_valid_o), 32'd0);
      chk("rst_resp_ready", 32'(if_resp_ready_o), 32'd0);

      req_q.push_back(32'h0);
      req_q.push_back(32'h4);
      req_q.push_back(32'h8);
      req_q.push_back(32'hC);
      pkt_q.push_back(mk(32'h0, 32'h0000_0013, 1'b0, 1'b0));
      pkt_q.push_back(mk(32'h4, 32'h0010_0093, 1'b0, 1'b0));
      pkt_q.push_back(mk(32'h8, 32'hC0DE_0008, 1'b0, 1'b0));

      cyc();
      rst_i = 1'b0;
      @(negedge clk_i);
      chk("lat_c0_valid", 32'(ifu_o_valid), 32'd0);
      chk("first_req_valid", 32'(if_req_valid_o), 32'd1);
      @(negedge clk_i);
      chk("lat_c1_valid", 32'(ifu_o_valid), 32'd0);
      @(negedge clk_i);
      chk("lat_c2_valid", 32'(ifu_o_valid), 32'd1);

      // Decode stall on the packet at 0x8.
      wait_req(32'h8, "wait_req_8");
      cyc();
      ifu_o_ready = 1'b0;
      wait_pkt(32'h8, "wait_pkt_8");
      for (int i = 0; i < 5; i++) begin
         chk("hold_valid", 32'(ifu_o_valid), 32'd1);
         chk("hold_pc", ifu_o_pc, 32'h8);
         chk("hold_instr", ifu_o_instr, 32'hC0DE_0008);
         chk("hold_no_req", 32'(if_req_valid_o), 32'd0);
         if (i < 4) @(negedge clk_i);
      end
      req_q.push_back(32'h100);
      pkt_q.push_back(mk(32'h100, 32'hC0DE_0100, 1'b0, 1'b0));
      cyc();
      resp_delay = 2;
      ifu_o_ready = 1'b1;

      // Flush while the 0xC fetch is outstanding; its late response must vanish.
      wait_req(32'hC, "wait_req_c");
      cyc();
      flush_valid_i = 1'b1;
      flush_pc_i = 32'h100;
      @(negedge clk_i);
      chk("wait_resp_ready", 32'(if_resp_ready_o), 32'd1);
      chk("flush_gates_req", 32'(if_req_valid_o), 32'd0);
      cyc();
      flush_valid_i = 1'b0;
      resp_delay = 0;
      @(negedge clk_i);
      chk("retarget_pc", if_req_pc_o, 32'h100);

      // Misaligned redirect: no bus traffic, flagged packets.
      pkt_q.push_back(mk(32'h102, 32'h0, 1'b1, 1'b0));
      pkt_q.push_back(mk(32'h106, 32'h0, 1'b1, 1'b0));
      wait_pkt(32'h100, "wait_pkt_100");
      cyc();
      flush_valid_i = 1'b1;
      flush_pc_i = 32'h102;
      cyc();
      flush_valid_i = 1'b0;

      // Back to aligned code with a bus error at 0x20.
      berr_addr = 32'h20;
      req_q.push_back(32'h20);
      req_q.push_back(32'h24);
      req_q.push_back(32'h28);
      pkt_q.push_back(mk(32'h20, 32'h0, 1'b0, 1'b1));
      pkt_q.push_back(mk(32'h24, 32'hC0DE_0024, 1'b0, 1'b0));
      wait_pkt(32'h106, "wait_pkt_106");
      cyc();
      flush_valid_i = 1'b1;
      flush_pc_i = 32'h20;
      cyc();
      flush_valid_i = 1'b0;

      // Reset while the 0x28 fetch is outstanding.
      wait_pkt(32'h24, "wait_pkt_24");
      cyc();
      resp_delay = 2;
      wait_req(32'h28, "wait_req_28");
      cyc();
      rst_i = 1'b1;
      @(negedge clk_i);
      chk("midrst_resp_ready", 32'(if_resp_ready_o), 32'd0);
      chk("midrst_req_valid", 32'(if_req_valid_o), 32'd0);
      req_q.push_back(32'h0);
      req_q.push_back(32'h4);
      req_q.push_back(32'h8);
      pkt_q.push_back(mk(32'h0, 32'h0000_0013, 1'b0, 1'b0));
      pkt_q.push_back(mk(32'h4, 32'h0010_0093, 1'b0, 1'b0));
      cyc();
      rst_i = 1'b0;
      resp_delay = 0;
      @(negedge clk_i);
      chk("post_rst_valid", 32'(ifu_o_valid), 32'd0);
      chk("post_rst_pc", ifu_o_pc, 32'h0);
      chk("post_rst_instr", ifu_o_instr, 32'h0);
      chk("post_rst_misalign", 32'(ifu_o_misalign), 32'd0);
      chk("post_rst_bus_err", 32'(ifu_o_bus_err), 32'd0);
      chk("post_rst_req_valid", 32'(if_req_valid_o), 32'd1);
      chk("post_rst_req_pc", if_req_pc_o, 32'h0);

      t = 0;
      while ((req_q.size() != 0 || pkt_q.size() != 0) && t < 60) begin
         @(posedge clk_i);
         #2;
         t++;
      end
      ifu_o_ready = 1'b0;
      chk("drain_req_q", 32'(req_q.size()), 32'd0);
      chk("drain_pkt_q", 32'(pkt_q.size()), 32'd0);
      repeat (4) @(negedge clk_i);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
